// File: rtl/lvds_input_pkg.sv
// Shared types for the LVDS ADC acquisition sequencer.
//   acq_state_t : sequencer states
//   acq_entry_t : FIFO entry layout at the default stream width
//   TKEEP_ALL   : all-bytes-valid keep mask at the default stream width
package lvds_input_pkg;

    localparam int ACQ_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } acq_state_t;

    typedef struct packed {
        logic                  last;
        logic [ACQ_DATA_W-1:0] data;
    } acq_entry_t;

    localparam logic [ACQ_DATA_W/8-1:0] TKEEP_ALL = {(ACQ_DATA_W/8){1'b1}};

endpackage

// File: rtl/lvds_input_acq_fifo.sv
// Synchronous first-word-fall-through FIFO for acquired samples.
//   clk   : clock
//   push  : write din (accepted when not full, or when full with a pop)
//   pop   : remove head entry (ignored when empty)
//   flush : clear pointers; overrides push and pop
//   full  : no free entry
//   empty : no valid entry
//   din   : write data
//   dout  : head entry, valid whenever !empty
module lvds_input_acq_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // A push while full is accepted when the head leaves in the same cycle.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_push_s = push & (~full | pop);
            do_pop_s  = pop & ~empty;
        end
    end

    // Pointer update; flush resets both pointers.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/lvds_input_acq_ctrl.sv
// LVDS ADC acquisition sequencer: arms on start, waits for a sync rising
// edge, captures dsize words into a FWFT FIFO and streams them as one
// AXI-Stream packet with TLAST. Supports auto re-arm and test pattern.
//   clk, reset              : clock, synchronous active-high reset
//   start, stop             : control pulses (stop wins)
//   start_rt, test          : real-time re-arm / test-pattern levels
//   dsize                   : words per packet, latched on accepted start
//   sync                    : external sync, already in clk domain
//   s_valid, s_data         : receiver word stream
//   m_axis_*                : AXI-Stream master
//   busy, armed             : state decode
//   sr_pc, sr_ovf, sr_cfg_err, pkt_cnt : sticky status and packet counter
module lvds_input_acq_ctrl
    import lvds_input_pkg::*;
#(
    parameter int DATA_W     = ACQ_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  start_rt,
    input  logic                  test,
    input  logic [31:0]           dsize,
    input  logic                  sync,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  m_axis_tvalid,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  armed,
    output logic                  sr_pc,
    output logic                  sr_ovf,
    output logic                  sr_cfg_err,
    output logic [PKT_CNT_W-1:0]  pkt_cnt
);

    acq_state_t           state_r;
    logic                 sync_q_r;
    logic [31:0]          dsize_r;
    logic                 rt_r;
    logic [31:0]          idx_r;
    logic                 sr_pc_r;
    logic                 sr_ovf_r;
    logic                 sr_cfg_err_r;
    logic [PKT_CNT_W-1:0] pkt_cnt_r;

    logic                 sync_edge_s;
    logic                 cap_wr_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 ovf_s;
    logic                 flush_s;
    logic                 entry_last_s;
    logic [DATA_W-1:0]    entry_data_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DATA_W:0]      fifo_dout_s;

    // Capture path: entry formation, push/drop decision and stream handshake.
    always_comb begin
        sync_edge_s  = sync & ~sync_q_r;
        cap_wr_s     = (state_r == CAPTURE) & s_valid & ~stop;
        entry_last_s = (idx_r == (dsize_r - 32'd1));
        if (test) begin
            entry_data_s = DATA_W'(idx_r);
        end else begin
            entry_data_s = s_data;
        end
        pop_s   = ~fifo_empty_s & m_axis_tready;
        push_s  = cap_wr_s & (~fifo_full_s | pop_s);
        ovf_s   = cap_wr_s & fifo_full_s & ~pop_s;
        flush_s = reset | stop;
    end

    lvds_input_acq_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .din   ({entry_last_s, entry_data_s}),
        .dout  (fifo_dout_s)
    );

    // Stream outputs; data and last are forced low while nothing is queued.
    always_comb begin
        m_axis_tvalid = ~fifo_empty_s;
        if (fifo_empty_s) begin
            m_axis_tdata = {DATA_W{1'b0}};
            m_axis_tlast = 1'b0;
        end else begin
            m_axis_tdata = fifo_dout_s[DATA_W-1:0];
            m_axis_tlast = fifo_dout_s[DATA_W];
        end
    end

    assign m_axis_tkeep = {(DATA_W/8){1'b1}};
    assign busy         = (state_r != IDLE);
    assign armed        = (state_r == ARMED);
    assign sr_pc        = sr_pc_r;
    assign sr_ovf       = sr_ovf_r;
    assign sr_cfg_err   = sr_cfg_err_r;
    assign pkt_cnt      = pkt_cnt_r;

    // Sequencer state, latched configuration, word index and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            sync_q_r     <= 1'b0;
            dsize_r      <= 32'd0;
            rt_r         <= 1'b0;
            idx_r        <= 32'd0;
            sr_pc_r      <= 1'b0;
            sr_ovf_r     <= 1'b0;
            sr_cfg_err_r <= 1'b0;
            pkt_cnt_r    <= {PKT_CNT_W{1'b0}};
        end else begin
            sync_q_r <= sync;
            if (stop) begin
                // Abort keeps sticky status and the packet count.
                state_r <= IDLE;
                idx_r   <= 32'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            if (dsize != 32'd0) begin
                                state_r      <= ARMED;
                                dsize_r      <= dsize;
                                rt_r         <= start_rt;
                                sr_pc_r      <= 1'b0;
                                sr_ovf_r     <= 1'b0;
                                sr_cfg_err_r <= 1'b0;
                                pkt_cnt_r    <= {PKT_CNT_W{1'b0}};
                            end else begin
                                sr_cfg_err_r <= 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if (sync_edge_s) begin
                            state_r <= CAPTURE;
                            idx_r   <= 32'd0;
                        end
                    end
                    CAPTURE: begin
                        if (s_valid) begin
                            // Dropped words still advance the index.
                            idx_r <= idx_r + 32'd1;
                            if (ovf_s) begin
                                sr_ovf_r <= 1'b1;
                            end
                            if (entry_last_s) begin
                                state_r <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (fifo_empty_s) begin
                            sr_pc_r   <= 1'b1;
                            pkt_cnt_r <= pkt_cnt_r + PKT_CNT_W'(1'b1);
                            state_r   <= rt_r ? ARMED : IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lvds_input_acq_ctrl.sv
module tb_lvds_input_acq_ctrl;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int PKT_CNT_W  = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 stop;
    logic                 start_rt;
    logic                 test;
    logic [31:0]          dsize;
    logic                 sync;
    logic                 s_valid;
    logic [DATA_W-1:0]    s_data;
    logic                 m_axis_tvalid;
    logic [DATA_W-1:0]    m_axis_tdata;
    logic [DATA_W/8-1:0]  m_axis_tkeep;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;
    logic                 busy;
    logic                 armed;
    logic                 sr_pc;
    logic                 sr_ovf;
    logic                 sr_cfg_err;
    logic [PKT_CNT_W-1:0] pkt_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int e     = 0;
    logic [DATA_W:0] beats[$];

    lvds_input_acq_ctrl #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PKT_CNT_W  (PKT_CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .start_rt      (start_rt),
        .test          (test),
        .dsize         (dsize),
        .sync          (sync),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .armed         (armed),
        .sr_pc         (sr_pc),
        .sr_ovf        (sr_ovf),
        .sr_cfg_err    (sr_cfg_err),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word_at(input int c);
        return 32'hDA7A_0000 + 32'(c);
    endfunction

    // One clock: drive the cycle's receiver word, log any handshake, step past the edge.
    task automatic tick();
        s_data = word_at(cyc);
        if (m_axis_tvalid && m_axis_tready) begin
            beats.push_back({m_axis_tlast, m_axis_tdata});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i, input logic last, input logic [31:0] data);
        if (i < beats.size()) begin
            chk(tag, 64'(beats[i]), {31'd0, last, data});
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; start_rt = 1'b0; test = 1'b0;
        dsize = 32'd0; sync = 1'b0; s_valid = 1'b0; s_data = '0; m_axis_tready = 1'b0;
        ticks(3);
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tkeep", 64'(m_axis_tkeep), 64'hF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_flags", 64'({sr_pc, sr_ovf, sr_cfg_err}), 64'd0);
        chk("rst_pkt", 64'(pkt_cnt), 64'd0);

        // Single shot, dsize=4, continuous words, tready=1
        dsize = 32'd4; s_valid = 1'b1; m_axis_tready = 1'b1; beats.delete();
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_armed", 64'(armed), 64'd1);
        ticks(3);
        sync = 1'b1; e = cyc; tick(); sync = 1'b0;
        chk("t1_capture", 64'({busy, armed}), 64'b10);
        ticks(12);
        chk("t1_nbeats", 64'(beats.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk_beat("t1_beat", k, (k == 3), word_at(e + 1 + k));
        end
        chk("t1_pc", 64'(sr_pc), 64'd1);
        chk("t1_pkt", 64'(pkt_cnt), 64'd1);
        chk("t1_idle", 64'(busy), 64'd0);

        // Test pattern with backpressure
        test = 1'b1; dsize = 32'd3; m_axis_tready = 1'b0; beats.delete();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        sync = 1'b1; tick(); sync = 1'b0;
        ticks(20);
        chk("t2_pc_clr", 64'(sr_pc), 64'd0);
        chk("t2_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), {30'd0, 1'b1, 1'b0, 32'd0});
        chk("t2_busy", 64'(busy), 64'd1);
        m_axis_tready = 1'b1;
        ticks(8);
        chk("t2_nbeats", 64'(beats.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk_beat("t2_beat", k, (k == 2), 32'(k));
        end
        chk("t2_ovf", 64'(sr_ovf), 64'd0);
        chk("t2_pc", 64'(sr_pc), 64'd1);

        // Overflow: 16 stored, words 17..20 dropped
        dsize = 32'd20; m_axis_tready = 1'b0; beats.delete();
        start = 1'b1; tick(); start = 1'b0;
        sync = 1'b1; tick(); sync = 1'b0;
        ticks(16);
        chk("t3_no_ovf_yet", 64'(sr_ovf), 64'd0);
        tick();
        chk("t3_ovf", 64'(sr_ovf), 64'd1);
        ticks(3);
        chk("t3_drain", 64'({busy, armed}), 64'b10);
        m_axis_tready = 1'b1;
        ticks(20);
        chk("t3_nbeats", 64'(beats.size()), 64'd16);
        for (int k = 0; k < 16; k++) begin
            chk_beat("t3_beat", k, 1'b0, 32'(k));
        end
        chk("t3_pc", 64'(sr_pc), 64'd1);
        chk("t3_ovf_sticky", 64'(sr_ovf), 64'd1);
        chk("t3_idle", 64'(busy), 64'd0);

        // Real-time: three packets of 2, with an edge during capture
        start_rt = 1'b1; dsize = 32'd2; beats.delete();
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_armed", 64'(armed), 64'd1);
        chk("t4_ovf_clr", 64'(sr_ovf), 64'd0);
        for (int p = 0; p < 3; p++) begin
            ticks(2);
            sync = 1'b1; tick();
            sync = 1'b0; tick();
            sync = 1'b1; tick();
            sync = 1'b0;
            ticks(4);
            chk("t4_rearm", 64'(armed), 64'd1);
            chk("t4_pkt", 64'(pkt_cnt), 64'(p + 1));
        end
        chk("t4_nbeats", 64'(beats.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk_beat("t4_beat", k, (k % 2 == 1), 32'(k % 2));
        end
        stop = 1'b1; tick(); stop = 1'b0;
        start_rt = 1'b0;
        chk("t4_stop_idle", 64'(busy), 64'd0);
        chk("t4_stop_keep_pkt", 64'(pkt_cnt), 64'd3);

        // Zero dsize rejected, then accepted start clears the error
        dsize = 32'd0;
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_cfg_err", 64'(sr_cfg_err), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_pkt_kept", 64'(pkt_cnt), 64'd3);
        dsize = 32'd5;
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_cfg_clr", 64'(sr_cfg_err), 64'd0);
        chk("t5_armed", 64'(armed), 64'd1);
        chk("t5_pkt_clr", 64'(pkt_cnt), 64'd0);

        // Stop mid-capture, then a clean packet from new words
        test = 1'b0; m_axis_tready = 1'b0; beats.delete();
        sync = 1'b1; tick(); sync = 1'b0;
        ticks(3);
        chk("t6_queued", 64'({m_axis_tvalid, busy}), 64'b11);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t6_stop", 64'({m_axis_tvalid, busy}), 64'b00);
        chk("t6_stop_tdata", 64'(m_axis_tdata), 64'd0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("t6_stop_wins", 64'(busy), 64'd0);
        dsize = 32'd2;
        start = 1'b1; tick(); start = 1'b0;
        dsize = 32'd9;
        m_axis_tready = 1'b1;
        ticks(2);
        sync = 1'b1; e = cyc; tick(); sync = 1'b0;
        ticks(8);
        chk("t6_nbeats", 64'(beats.size()), 64'd2);
        chk_beat("t6_beat0", 0, 1'b0, word_at(e + 1));
        chk_beat("t6_beat1", 1, 1'b1, word_at(e + 2));
        chk("t6_pkt", 64'(pkt_cnt), 64'd1);
        chk("t6_idle", 64'(busy), 64'd0);

        // Reset mid-packet clears stream, state and sticky status
        start_rt = 1'b1; test = 1'b1; dsize = 32'd2;
        start = 1'b1; tick(); start = 1'b0;
        sync = 1'b1; tick(); sync = 1'b0;
        ticks(6);
        chk("t7_pkt", 64'(pkt_cnt), 64'd1);
        chk("t7_armed", 64'(armed), 64'd1);
        m_axis_tready = 1'b0;
        sync = 1'b1; tick(); sync = 1'b0;
        tick();
        chk("t7_queued", 64'(m_axis_tvalid), 64'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t7_rst_stream", 64'({m_axis_tvalid, busy}), 64'b00);
        chk("t7_rst_flags", 64'({sr_pc, sr_ovf, sr_cfg_err}), 64'd0);
        chk("t7_rst_pkt", 64'(pkt_cnt), 64'd0);
        start_rt = 1'b0;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
